// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: E-stage op encodings,
// decoder opcode/funct constants and the FSM state type.
package md_unit_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  // R-type funct codes the decoder maps onto md_op_E / md_instr_D
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1a;
  localparam logic [5:0] FN_DIVU    = 6'h1b;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  function automatic logic is_start_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath producing the {HI, LO} pair for
// mult/multu/div/divu, including divide-by-zero and signed overflow cases.
module md_calc
  import md_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               div_zero;
  logic               div_ovf;
  logic signed [31:0] sb_safe;
  logic        [31:0] ub_safe;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quot_u;
  logic        [31:0] rem_u;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Substituting a divisor of 1 keeps the dividers defined; for the
  // 0x80000000 / -1 overflow it also yields exactly quotient=a, remainder=0.
  assign div_zero = (b == 32'd0);
  assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign sb_safe  = (div_zero || div_ovf) ? 32'sd1 : $signed(b);
  assign ub_safe  = div_zero ? 32'd1 : b;

  assign quot_s = $signed(a) / sb_safe;
  assign rem_s  = $signed(a) % sb_safe;
  assign quot_u = a / ub_safe;
  assign rem_u  = a % ub_safe;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op)
      MD_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MD_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      MD_DIV: begin
        res_hi = div_zero ? a : rem_s;
        res_lo = div_zero ? 32'hFFFF_FFFF : quot_s;
      end
      MD_DIVU: begin
        res_hi = div_zero ? a : rem_u;
        res_lo = div_zero ? 32'hFFFF_FFFF : quot_u;
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit owning HI/LO; models multi-cycle latency with a
// busy counter and requests D-stage stalls for HI/LO users while busy.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  md_op_E,
  input  logic [31:0] a_E,
  input  logic [31:0] b_E,
  input  logic        md_instr_D,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        md_stall
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  md_state_e         state;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       pending_hi;
  logic [31:0]       pending_lo;
  logic [31:0]       calc_hi;
  logic [31:0]       calc_lo;
  logic              start_E;

  md_calc u_calc (
    .op     (md_op_E),
    .a      (a_E),
    .b      (b_E),
    .res_hi (calc_hi),
    .res_lo (calc_lo)
  );

  assign start_E  = is_start_op(md_op_E);
  assign md_stall = md_instr_D & (busy | start_E);

  // mthi/mtlo write straight through in any state; the completion commit is
  // written after them so a finishing op overwrites a stray move-to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      pending_hi <= '0;
      pending_lo <= '0;
      hi         <= '0;
      lo         <= '0;
      busy       <= 1'b0;
    end else begin
      if (md_op_E == MD_MTHI) hi <= a_E;
      if (md_op_E == MD_MTLO) lo <= a_E;

      case (state)
        ST_IDLE: begin
          if (start_E) begin
            pending_hi <= calc_hi;
            pending_lo <= calc_lo;
            cnt        <= ((md_op_E == MD_MULT) || (md_op_E == MD_MULTU)) ? MULT_LOAD : DIV_LOAD;
            state      <= ST_BUSY;
            busy       <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (cnt == CNT_W'(1)) begin
            hi    <= pending_hi;
            lo    <= pending_lo;
            cnt   <= '0;
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: latency, arithmetic results,
// special divides, stall request, move-to writes, collisions and reset.
module tb_md_unit;
  import md_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [2:0]  md_op_E;
  logic [31:0] a_E;
  logic [31:0] b_E;
  logic        md_instr_D;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        md_stall;

  int errors = 0;
  int checks = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .md_op_E    (md_op_E),
    .a_E        (a_E),
    .b_E        (b_E),
    .md_instr_D (md_instr_D),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .md_stall   (md_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op for a single cycle, then counts busy cycles (bounded).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    md_op_E = op;
    a_E     = a;
    b_E     = b;
    tick();
    md_op_E = MD_NONE;
    cycles  = 0;
    while (busy && cycles < 40) begin
      cycles++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    md_op_E    = MD_MULT;
    a_E        = 32'd3;
    b_E        = 32'd4;
    md_instr_D = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_hold cyc%0d: hi=%h lo=%h busy=%b, want 0/0/0", i, hi, lo, busy);
      end
    end
    rst_n   = 1'b1;
    md_op_E = MD_NONE;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release: hi=%h lo=%h busy=%b, want 0/0/0", hi, lo, busy);
    end
  endtask

  task automatic test_mult();
    int n;
    run_op(MD_MULT, 32'hFFFF_FFFF, 32'd2, n);
    checks++;
    if (n !== 5) begin
      errors++;
      $display("[TB] FAIL mult_latency: busy cycles=%0d, want 5", n);
    end
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin
      errors++;
      $display("[TB] FAIL mult_result: hi=%h lo=%h, want ffffffff/fffffffe", hi, lo);
    end
  endtask

  task automatic test_multu();
    int n;
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, n);
    checks++;
    if (n !== 5 || hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin
      errors++;
      $display("[TB] FAIL multu: cycles=%0d hi=%h lo=%h, want 5 00000001/fffffffe", n, hi, lo);
    end
  endtask

  task automatic test_div();
    int n;
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, n);
    checks++;
    if (n !== 10) begin
      errors++;
      $display("[TB] FAIL div_latency: busy cycles=%0d, want 10", n);
    end
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      errors++;
      $display("[TB] FAIL div_result: hi=%h lo=%h, want ffffffff/fffffffd", hi, lo);
    end
    run_op(MD_DIVU, 32'd100, 32'd7, n);
    checks++;
    if (hi !== 32'd2 || lo !== 32'd14) begin
      errors++;
      $display("[TB] FAIL divu_result: hi=%h lo=%h, want 00000002/0000000e", hi, lo);
    end
  endtask

  task automatic test_special_div();
    int n;
    run_op(MD_DIVU, 32'd7, 32'd0, n);
    checks++;
    if (n !== 10 || hi !== 32'd7 || lo !== 32'hFFFF_FFFF) begin
      errors++;
      $display("[TB] FAIL divu_by_zero: cycles=%0d hi=%h lo=%h, want 10 00000007/ffffffff", n, hi, lo);
    end
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
    checks++;
    if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
      errors++;
      $display("[TB] FAIL div_overflow: hi=%h lo=%h, want 00000000/80000000", hi, lo);
    end
  endtask

  task automatic test_stall();
    int n;
    md_instr_D = 1'b1;
    md_op_E    = MD_MULT;
    a_E        = 32'd2;
    b_E        = 32'd3;
    #1;
    checks++;
    if (md_stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_start: md_stall=%b, want 1", md_stall);
    end
    tick();
    md_op_E = MD_NONE;
    n = 0;
    while (busy && n < 40) begin
      checks++;
      if (md_stall !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stall_busy cyc%0d: md_stall=%b, want 1", n, md_stall);
      end
      n++;
      tick();
    end
    checks++;
    if (n !== 5 || md_stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_release: cycles=%0d md_stall=%b, want 5 0", n, md_stall);
    end
    md_instr_D = 1'b0;
    checks++;
    if (lo !== 32'd6) begin
      errors++;
      $display("[TB] FAIL stall_result: lo=%h, want 00000006", lo);
    end
  endtask

  task automatic test_mthi();
    md_op_E = MD_MTHI;
    a_E     = 32'h0000_1234;
    tick();
    md_op_E = MD_NONE;
    checks++;
    if (hi !== 32'h0000_1234 || lo !== 32'd6 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mthi: hi=%h lo=%h busy=%b, want 00001234/00000006/0", hi, lo, busy);
    end
    md_op_E = MD_MTLO;
    a_E     = 32'hCAFE_0001;
    tick();
    md_op_E = MD_NONE;
    checks++;
    if (hi !== 32'h0000_1234 || lo !== 32'hCAFE_0001 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mtlo: hi=%h lo=%h busy=%b, want 00001234/cafe0001/0", hi, lo, busy);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    md_op_E = MD_MULT;
    a_E     = 32'd3;
    b_E     = 32'd4;
    tick();
    md_op_E = MD_NONE;
    tick();
    md_op_E = MD_MULT;
    a_E     = 32'd5;
    b_E     = 32'd6;
    tick();
    md_op_E = MD_NONE;
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 3) begin
      errors++;
      $display("[TB] FAIL restart_ignored_latency: remaining busy=%0d, want 3", n);
    end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd12) begin
      errors++;
      $display("[TB] FAIL restart_ignored_result: hi=%h lo=%h, want 00000000/0000000c", hi, lo);
    end
  endtask

  task automatic test_reset_mid_op();
    rst_n = 1'b0;
    tick();
    rst_n   = 1'b1;
    md_op_E = MD_MULT;
    a_E     = 32'd7;
    b_E     = 32'd9;
    tick();
    md_op_E = MD_NONE;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_busy: busy=%b, want 0", busy);
    end
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_result: hi=%h lo=%h busy=%b, want 0/0/0", hi, lo, busy);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    md_op_E    = MD_NONE;
    a_E        = '0;
    b_E        = '0;
    md_instr_D = 1'b0;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_special_div();
    test_stall();
    test_mthi();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
